// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings and FSM states.
package md_pkg;

  localparam logic [1:0] MD_OP_MUL  = 2'b00;
  localparam logic [1:0] MD_OP_MULU = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;
  localparam logic [1:0] MD_OP_DIVU = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } md_state_e;

  // Bit 0 of the op selects the unsigned variant.
  function automatic logic md_op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation; turns a magnitude into a signed value and back.
module md_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] mag_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? -mag_i : mag_i;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per clock,
// followed by a single sign-correction cycle and a held result.
module muldiv_iter
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned AW = 2 * WIDTH + 1;
  // The counter reaches WIDTH on the idle cycle that closes CALC.
  localparam logic [CNT_W-1:0] CntDone = CNT_W'(WIDTH);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic             div_zero_q, div_zero_d;

  // Operand conditioning at accept.
  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_signed = md_op_signed(op);
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];

  md_sign_fix #(.WIDTH(WIDTH)) u_fix_a (.mag_i(a), .neg_i(a_neg), .val_o(a_mag));
  md_sign_fix #(.WIDTH(WIDTH)) u_fix_b (.mag_i(b), .neg_i(b_neg), .val_o(b_mag));

  // Result sign correction used in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  md_sign_fix #(.WIDTH(2 * WIDTH)) u_fix_prod (
    .mag_i(acc_q[2*WIDTH-1:0]),
    .neg_i(neg_lo_q),
    .val_o(prod_fix)
  );
  md_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
    .mag_i(acc_q[WIDTH-1:0]),
    .neg_i(neg_lo_q),
    .val_o(quot_fix)
  );
  md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .mag_i(acc_q[2*WIDTH-1:WIDTH]),
    .neg_i(neg_hi_q),
    .val_o(rem_fix)
  );

  // Multiply: multiplier sits in the low half and is consumed LSB first.
  logic [WIDTH:0] mul_upper;
  logic [AW-1:0]  mul_next;

  assign mul_upper = acc_q[AW-1:WIDTH] + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
  assign mul_next  = {1'b0, mul_upper, acc_q[WIDTH-1:1]};

  // Divide: remainder in the upper W+1 bits, quotient bits shift in from the bottom.
  logic [AW-1:0]  div_shift, div_next;
  logic [WIDTH:0] div_trial;

  assign div_shift = {acc_q[2*WIDTH-1:0], 1'b0};
  assign div_trial = div_shift[AW-1:WIDTH] - {1'b0, opnd_q};
  assign div_next  = div_trial[WIDTH] ? div_shift
                                      : {div_trial, div_shift[WIDTH-1:1], 1'b1};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (in_valid) begin
            state_d  = MD_CALC;
            cnt_d    = '0;
            is_div_d = op[1];
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            dz_d     = op[1] & (b == '0);
            opnd_d   = op[1] ? b_mag : a_mag;
            acc_d    = {{(WIDTH + 1){1'b0}}, (op[1] ? a_mag : b_mag)};
          end
        end
        MD_CALC: begin
          if (cnt_q == CntDone) begin
            state_d = MD_FIX;
          end else begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MD_FIX: begin
          // A zero divisor leaves remainder = dividend; only the quotient is forced.
          hi_d       = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_d       = is_div_q ? (dz_q ? '1 : quot_fix) : prod_fix[WIDTH-1:0];
          div_zero_d = dz_q;
          state_d    = MD_DONE;
        end
        MD_DONE: begin
          if (out_ready) state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == MD_IDLE);
  assign out_valid = (state_q == MD_DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_muldiv_iter;
  import md_pkg::*;

  logic        clk, rst_n;

  logic        in_valid32, in_ready32, flush32, out_valid32, out_ready32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        in_valid8, in_ready8, flush8, out_valid8, out_ready8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   total  = 0;
  int   passed = 0;

  muldiv_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32), .op(op32),
    .a(a32), .b(b32), .flush(flush32), .out_valid(out_valid32), .out_ready(out_ready32),
    .hi(hi32), .lo(lo32), .div_zero(dz32)
  );

  muldiv_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .flush(flush8), .out_valid(out_valid8), .out_ready(out_ready8),
    .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Reference arithmetic: plain signed/unsigned 64-bit math, masked to w bits.
  function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo, output logic dz);
    longint unsigned mask, ua, ub, p;
    longint          sa, sb, q, r;
    bit              sgn;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sgn  = (op == MD_OP_MUL) || (op == MD_OP_DIV);
    sa   = longint'(ua);
    sb   = longint'(ub);
    if (sgn && ua[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && ub[w-1]) sb = sb - (longint'(1) << w);
    dz = 1'b0;
    if (op == MD_OP_MUL || op == MD_OP_MULU) begin
      p  = sgn ? $unsigned(sa * sb) : ua * ub;
      hi = 32'((p >> w) & mask);
      lo = 32'(p & mask);
    end else if (ub == 0) begin
      hi = 32'(ua);
      lo = 32'(mask);
      dz = 1'b1;
    end else if (sgn) begin
      q  = sa / sb;
      r  = sa % sb;
      hi = 32'($unsigned(r) & mask);
      lo = 32'($unsigned(q) & mask);
    end else begin
      hi = 32'((ua % ub) & mask);
      lo = 32'((ua / ub) & mask);
    end
  endfunction

  function automatic logic get_ov(input bit w8);
    return w8 ? out_valid8 : out_valid32;
  endfunction
  function automatic logic get_ir(input bit w8);
    return w8 ? in_ready8 : in_ready32;
  endfunction
  function automatic logic [31:0] get_hi(input bit w8);
    return w8 ? {24'd0, hi8} : hi32;
  endfunction
  function automatic logic [31:0] get_lo(input bit w8);
    return w8 ? {24'd0, lo8} : lo32;
  endfunction
  function automatic logic get_dz(input bit w8);
    return w8 ? dz8 : dz32;
  endfunction

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid32) begin
        chk("result_expected32", 64'(q32.size() > 0), 64'd1);
        if (q32.size() > 0) begin
          e = q32[0];
          chk("cmp_hi32", hi32, e.hi);
          chk("cmp_lo32", lo32, e.lo);
          chk("cmp_dz32", dz32, e.dz);
          if (out_ready32) void'(q32.pop_front());
        end
      end
      if (out_valid8) begin
        chk("result_expected8", 64'(q8.size() > 0), 64'd1);
        if (q8.size() > 0) begin
          e = q8[0];
          chk("cmp_hi8", hi8, e.hi);
          chk("cmp_lo8", lo8, e.lo);
          chk("cmp_dz8", dz8, e.dz);
          if (out_ready8) void'(q8.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit w8, input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      in_valid8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      in_valid32 = v; op32 = op; a32 = a; b32 = b;
    end
  endtask

  task automatic set_ready(input bit w8, input logic r);
    if (w8) out_ready8 = r;
    else out_ready32 = r;
  endtask

  // Called at posedge+1 with the unit idle. Literal expectations pin both model and DUT.
  task automatic do_op(input bit w8, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input int hold);
    logic [31:0] mh, ml;
    logic        md;
    int          n, w;
    w = w8 ? 8 : 32;
    model(w, op, a, b, mh, ml, md);
    chk("model_hi", mh, ehi);
    chk("model_lo", ml, elo);
    chk("model_dz", md, edz);
    if (w8) q8.push_back('{hi: mh, lo: ml, dz: md});
    else q32.push_back('{hi: mh, lo: ml, dz: md});
    drive(w8, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w8, 1'b0, 2'b00, 32'd0, 32'd0);
    n = 0;
    while (!get_ov(w8) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, w + 2);
    chk("lit_hi", get_hi(w8), ehi);
    chk("lit_lo", get_lo(w8), elo);
    chk("lit_dz", get_dz(w8), edz);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("busy_in_ready", get_ir(w8), 0);
      chk("held_out_valid", get_ov(w8), 1);
      chk("held_hi", get_hi(w8), ehi);
      chk("held_lo", get_lo(w8), elo);
    end
    set_ready(w8, 1'b1);
    @(posedge clk); #1;
    set_ready(w8, 1'b0);
    chk("taken_out_valid", get_ov(w8), 0);
    chk("taken_in_ready", get_ir(w8), 1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    in_valid32 = 0; flush32 = 0; out_ready32 = 0; op32 = 0; a32 = 0; b32 = 0;
    in_valid8  = 0; flush8  = 0; out_ready8  = 0; op8  = 0; a8  = 0; b8  = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready32, 1);
    chk("rst_out_valid", out_valid32, 0);
    chk("rst_hi", hi32, 0);
    chk("rst_lo", lo32, 0);
    chk("rst_dz", dz32, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(0, MD_OP_MUL,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
    do_op(0, MD_OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
    do_op(0, MD_OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         0, 0);
    do_op(0, MD_OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    do_op(0, MD_OP_DIVU, 32'd7,         32'd2,        32'd1,         32'd3,         0, 0);
    do_op(0, MD_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0, 0);
    do_op(0, MD_OP_DIVU, 32'h1234,      32'd0,        32'h1234,      32'hFFFF_FFFF, 1, 5);
    do_op(0, MD_OP_DIV,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 0);
    do_op(0, MD_OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0, 0);
    do_op(0, MD_OP_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         0, 0);

    do_op(1, MD_OP_MULU, 32'hFF, 32'hFF, 32'hFE, 32'h01, 0, 0);
    do_op(1, MD_OP_DIV,  32'h80, 32'hFF, 32'h00, 32'h80, 0, 0);
    do_op(1, MD_OP_MUL,  32'h80, 32'h80, 32'h40, 32'h00, 0, 0);
    do_op(1, MD_OP_DIVU, 32'h10, 32'h00, 32'h10, 32'hFF, 1, 2);

    // Flush ten cycles into CALC: the previous result must survive untouched.
    drive(0, 1'b1, MD_OP_MULU, 32'd3, 32'd5);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("calc_busy", in_ready32, 0);
    flush32 = 1'b1;
    @(posedge clk); #1;
    flush32 = 1'b0;
    chk("flush_in_ready", in_ready32, 1);
    chk("flush_out_valid", out_valid32, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid32) seen++;
    end
    chk("flush_no_valid", seen, 0);
    chk("flush_hi_kept", hi32, 32'h4000_0000);
    chk("flush_lo_kept", lo32, 32'h0);

    // Flush together with an offered op in IDLE discards the op.
    drive(0, 1'b1, MD_OP_MULU, 32'd3, 32'd5);
    flush32 = 1'b1;
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 32'd0, 32'd0);
    flush32 = 1'b0;
    chk("idle_flush_in_ready", in_ready32, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid32) seen++;
    end
    chk("idle_flush_no_valid", seen, 0);
    chk("idle_flush_lo_kept", lo32, 32'h0);

    // Asynchronous reset mid-CALC clears outputs without waiting for an edge.
    drive(0, 1'b1, MD_OP_DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready32, 1);
    chk("arst_out_valid", out_valid32, 0);
    chk("arst_hi", hi32, 0);
    chk("arst_lo", lo32, 0);
    chk("arst_dz", dz32, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, MD_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
